// File: rtl/shared_reg_arbiter_pkg.sv
// arb_pkg: definitions shared by shared_reg_arbiter and its storage sub-module.
//   arb_state_e : FSM encoding (IDLE = 0, BUSY = 1)
//   IDX_W       : width of the owner / round-robin pointer fields
//   MAX_REQ     : largest supported requester count
//   rr_pick     : round-robin winner search (request vector, pointer -> index)
package arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int IDX_W   = 3;
  localparam int MAX_REQ = 8;

  // Finds the first set request starting at ptr and walking upward with wrap
  // at n_req. ptr < n_req always, so ptr + i < 2*n_req and one conditional
  // subtraction replaces a modulo. Returns 0 when nothing is requested; the
  // caller only uses the result when at least one request is set.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req_vec,
    input logic [IDX_W-1:0]   ptr,
    input int                 n_req
  );
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx3;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= n_req) idx = idx - n_req;
      idx3 = IDX_W'(idx);
      if ((i < n_req) && !found && req_vec[idx3]) begin
        pick  = idx3;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_dff_arst_en.sv
// dff_arst_en: WIDTH-bit storage register with load enable.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset, clears q to 0
//   en   : load enable, q <= d when high
//   d    : load data
//   q    : register contents
module dff_arst_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter granting one of N_REQ requesters
// ownership of a single shared WIDTH-bit register.
//   clk     : rising-edge clock
//   rstn    : asynchronous active-low reset
//   req     : per-requester level request
//   wdata   : requester i data in wdata[i*WIDTH +: WIDTH]
//   gnt     : registered one-hot grant, zero when idle
//   owner   : current or most recent owner index
//   q       : shared register contents
//   q_valid : q has been loaded at least once since reset
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant; pick next owner from ptr when any req is set
// BUSY  | gnt held; load owner data each cycle its req is high; release
//       | when the owner drops req or after MAX_HOLD loads
module shared_reg_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [IDX_W-1:0]       owner,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid
);

  localparam logic [3:0]       HOLD_LAST = 4'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [3:0]       hcnt_q, hcnt_d;
  logic             q_valid_q;

  logic [MAX_REQ-1:0] req_ext;
  logic               own_req;
  logic [WIDTH-1:0]   own_data;
  logic               load_en;

  // Zero-extend req so a 3-bit owner can index it for any N_REQ.
  always_comb begin
    req_ext             = '0;
    req_ext[N_REQ-1:0]  = req;
    own_req             = req_ext[owner_q];
    own_data            = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == IDX_W'(i)) own_data = wdata[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;
    load_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          owner_d = rr_pick(req_ext, ptr_q, N_REQ);
          gnt_d   = ONE_HOT0 << owner_d;
          hcnt_d  = 4'd0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        load_en = own_req;
        if (own_req) hcnt_d = hcnt_q + 4'd1;
        // A forced release still takes this cycle's load.
        if (!own_req || (hcnt_q == HOLD_LAST)) begin
          gnt_d   = '0;
          ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      hcnt_q    <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      if (load_en) q_valid_q <= 1'b1;
    end
  end

  dff_arst_en #(
    .WIDTH(WIDTH)
  ) u_q_reg (
    .clk (clk),
    .rstn(rstn),
    .en  (load_en),
    .d   (own_data),
    .q   (q)
  );

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign q_valid = q_valid_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
module tb_shared_reg_arbiter;

  localparam int N_REQ    = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  req  = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt;
  logic [2:0]  owner;
  logic [7:0]  q;
  logic        q_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: a grant is a "session" counting loads and cycles.
  bit m_busy  = 0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_loads = 0;
  int m_cycles = 0;
  int m_gnt   = 0;
  int m_q     = 0;
  bit m_qv    = 0;
  int grant_q[$];
  int len_q[$];

  always #5 clk = ~clk;

  shared_reg_arbiter #(
    .N_REQ(N_REQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .rstn(rstn), .req(req), .wdata(wdata),
    .gnt(gnt), .owner(owner), .q(q), .q_valid(q_valid)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rstn) begin : model
    int  idx;
    bit  found;
    if (!rstn) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_loads = 0; m_cycles = 0;
      m_gnt = 0; m_q = 0; m_qv = 0;
    end else if (!m_busy) begin
      if (req != 0) begin
        found = 0;
        for (int k = 0; k < N_REQ; k++) begin
          idx = (m_ptr + k) % N_REQ;
          if (!found && req[idx]) begin
            m_owner = idx;
            found = 1;
          end
        end
        m_gnt = 1 << m_owner;
        m_busy = 1; m_loads = 0; m_cycles = 0;
        grant_q.push_back(m_owner);
      end
    end else begin
      m_cycles++;
      if (req[m_owner]) begin
        m_q  = int'(wdata[m_owner*WIDTH +: WIDTH]);
        m_qv = 1;
        m_loads++;
      end
      if (!req[m_owner] || m_loads == MAX_HOLD) begin
        m_busy = 0;
        m_gnt  = 0;
        m_ptr  = (m_owner + 1) % N_REQ;
        len_q.push_back(m_cycles);
      end
    end
  end

  always @(negedge clk) begin
    check("gnt", int'(gnt), m_gnt);
    check("owner", int'(owner), m_owner);
    check("q", int'(q), m_q);
    check("q_valid", int'(q_valid), int'(m_qv));
  end

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req  = '0;
    next_cycle();
    rstn = 1'b1;
    grant_q.delete();
    len_q.delete();
  endtask

  initial begin
    // reset held with all requests high
    rstn = 1'b0;
    req = 4'hF;
    wdata = $urandom;
    repeat (3) begin
      next_cycle();
      check("rst_gnt", int'(gnt), 0);
      check("rst_q", int'(q), 0);
      check("rst_qv", int'(q_valid), 0);
    end
    rstn = 1'b1;
    grant_q.delete();
    len_q.delete();
    next_cycle();
    check("rst_release_gnt", int'(gnt), 1);

    // round robin with all requests held: 5 grants of 4 cycles
    repeat (24) begin
      wdata = $urandom;
      next_cycle();
    end
    for (int i = 0; i < 5; i++) begin
      check("rr_order", (i < grant_q.size()) ? grant_q[i] : -1, i % N_REQ);
      check("rr_len", (i < len_q.size()) ? len_q[i] : -1, MAX_HOLD);
    end

    // single requester, then wrap from ptr=3
    do_reset();
    wdata = '0;
    wdata[2*8 +: 8] = 8'hA5;
    req = 4'b0100;
    next_cycle();
    check("single_gnt", int'(gnt), 4'b0100);
    check("single_owner", int'(owner), 2);
    next_cycle();
    next_cycle();
    check("single_q", int'(q), 8'hA5);
    req = 4'b0000;
    next_cycle();
    check("single_rel_gnt", int'(gnt), 0);
    check("single_hold_q", int'(q), 8'hA5);
    check("single_qv", int'(q_valid), 1);
    req = 4'b1001;
    next_cycle();
    check("wrap_owner3", int'(owner), 3);
    check("wrap_gnt3", int'(gnt), 4'b1000);
    repeat (4) next_cycle();
    check("wrap_rel_gnt", int'(gnt), 0);
    next_cycle();
    check("wrap_owner0", int'(owner), 0);
    check("wrap_gnt0", int'(gnt), 4'b0001);
    req = 4'b0000;
    next_cycle();
    check("wrap_seq0", (grant_q.size() > 0) ? grant_q[0] : -1, 2);
    check("wrap_seq1", (grant_q.size() > 1) ? grant_q[1] : -1, 3);
    check("wrap_seq2", (grant_q.size() > 2) ? grant_q[2] : -1, 0);

    // forced release with incrementing data
    do_reset();
    wdata = '0;
    wdata[7:0] = 8'd1;
    req = 4'b0001;
    next_cycle();
    check("force_gnt", int'(gnt), 1);
    for (int v = 1; v <= 4; v++) begin
      wdata[7:0] = 8'(v);
      next_cycle();
      check("force_q", int'(q), v);
    end
    check("force_rel_gnt", int'(gnt), 0);
    wdata[7:0] = 8'd5;
    next_cycle();
    check("force_regrant", int'(gnt), 1);
    check("force_idle_noload", int'(q), 4);
    next_cycle();
    check("force_continue", int'(q), 5);
    req = 4'b0000;
    next_cycle();

    // reset mid-grant
    do_reset();
    wdata[15:8] = 8'h3C;
    req = 4'b0010;
    next_cycle();
    next_cycle();
    check("mid_q_pre", int'(q), 8'h3C);
    check("mid_gnt_pre", int'(gnt), 4'b0010);
    #2 rstn = 1'b0;
    #1;
    check("mid_q_now", int'(q), 0);
    check("mid_gnt_now", int'(gnt), 0);
    check("mid_qv_now", int'(q_valid), 0);
    next_cycle();
    check("mid_q_after", int'(q), 0);
    check("mid_gnt_after", int'(gnt), 0);
    rstn = 1'b1;
    req = 4'b0000;
    next_cycle();

    // randomized traffic with occasional resets
    repeat (600) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      wdata = $urandom;
      if ($urandom_range(0, 149) == 0) begin
        rstn = 1'b0;
        next_cycle();
        rstn = 1'b1;
      end else begin
        next_cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter that shares one WIDTH-bit asynchronously reset data register among N_REQ requesters. Each requester raises `req` with its data on its `wdata` slice. The arbiter grants exactly one owner at a time and loads that owner's data into the register while it holds the grant. It sits in front of the lab's async-reset D-register storage and is the only writer of that register.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 8: data register width.
- `MAX_HOLD`, default 4: maximum consecutive BUSY cycles per grant, 1..15.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `req`  in  N_REQ: request per requester; level-sensitive.
- `wdata`  in  N_REQ*WIDTH: slice i = `wdata[i*WIDTH +: WIDTH]` belongs to requester i.
- `gnt`  out  N_REQ: registered one-hot grant; all zero when idle.
- `owner`  out  3: index of the current or most recent owner.
- `q`  out  WIDTH: shared register contents.
- `q_valid`  out  1: high once `q` has been loaded at least once since reset.

## Operation
- Reset (async, `rstn`=0) forces: state IDLE, `gnt`=0, `owner`=0, `q`=0, `q_valid`=0, round-robin pointer `ptr`=0, hold counter `hcnt`=0. Outputs change immediately, without waiting for a clock edge. Reset mid-grant discards the grant; no partial load completes.
- State machine has two states: IDLE and BUSY.
- IDLE, no `req` bits set: remain in IDLE.
- IDLE, any `req` set: select the first set bit searching from `ptr` upward with wrap (`ptr`, `ptr`+1, … N_REQ-1, 0, …). Set `owner` = winner, `gnt` = one-hot(winner), `hcnt`=0, go to BUSY.
- BUSY, each cycle:
  - If `req[owner]`=1: `q` <= `wdata[owner]`, `q_valid` <= 1, `hcnt` <= `hcnt`+1.
  - Release when `req[owner]`=0, or when `req[owner]`=1 and `hcnt`==MAX_HOLD-1. In the forced case the load in that same cycle still happens.
  - On release: `gnt` <= 0, `ptr` <= (`owner`+1) mod N_REQ, next state IDLE.
- Requests from non-owners during BUSY are ignored. They are not latched; the requester must hold `req`.
- `q` and `owner` hold their values after release. `q_valid` never falls except on reset.
- Width rules:
  - `hcnt` is 4 bits.
  - `ptr` and `owner` are 3 bits, with upper bits zero when N_REQ<8.
  - `ptr` wraps N_REQ-1 -> 0.

## Timing
- Request to grant: `req` sampled at edge k in IDLE gives `gnt` high after edge k.
- First load: edge k+1 (first BUSY edge), provided `req[owner]` is still high. `q` is visible after edge k+1.
- Release: `gnt` falls after the releasing edge, leaving at least one IDLE cycle between grants. The next grant is no earlier than one edge later.
- Throughput is bounded: a requester holding `req` continuously gets at most MAX_HOLD loads per grant.
- Fairness: any continuously asserted `req` is granted within N_REQ-1 intervening grants.
- A requester dropping `req` in the same cycle as its grant gets no load; release occurs on the first BUSY edge.

## Structure
- Shared package `arb_pkg` holds:
  - state encoding (IDLE=1'b0, BUSY=1'b1);
  - the `owner`/`ptr` width constant (3);
  - the round-robin pick function (request vector, pointer -> index).
- Sub-module `dff_arst_en`: WIDTH-parameterised register with `clk`, `rstn` (async active-low, clears to 0), `en`, `d`, `q`. It is instantiated once for `q`, with `en` = BUSY && `req[owner]`.
- Top level contains only the FSM, pointer, hold counter and data mux.

## Test plan
- Reset: drive `req`=4'b1111 with `rstn`=0 across several edges -> `gnt`=0, `q`=0, `q_valid`=0 throughout. Deassert `rstn` -> `gnt`=4'b0001 one edge later.
- Single requester: `req`=4'b0100, `wdata[2]`=8'hA5 held 2 BUSY cycles then dropped -> `gnt`=4'b0100, `q`=8'hA5, `q_valid`=1. IDLE follows, then `ptr`=3.
- Round robin: `req`=4'b1111 held continuously, MAX_HOLD=4 -> grant order 0,1,2,3,0. Each grant lasts exactly 4 cycles with one IDLE cycle between grants.
- Forced release: `req`=4'b0001 only, with `wdata[0]` incrementing 1,2,3,… -> loads 4 values and releases. Next it re-grants 0 after 1 IDLE cycle (wrap search), and `q` continues from 5.
- Wrap: `ptr`=3 with `req`=4'b1001 -> owner 3 first, then owner 0.
- Reset mid-grant: assert `rstn`=0 half a cycle into BUSY with `q`=8'h3C -> `q`=0, `gnt`=0 immediately, no load at the following edge.
